// File: rtl/exec_datapath.sv
// Execute datapath: register file, operand-B barrel shifter, ALU and NZCV flags,
// sequenced IDLE -> READ -> EXEC -> WB with a valid/ready operation handshake.
module exec_datapath #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    localparam int RA_W  = $clog2(NREGS),
    localparam int SH_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [1:0]        shift_op,
    input  logic              sel_shift,
    input  logic [7:0]        shift_imm,
    input  logic              sel_A,
    input  logic              sel_B,
    input  logic [DATA_W-1:0] imm,
    input  logic [RA_W-1:0]   a_addr,
    input  logic [RA_W-1:0]   b_addr,
    input  logic [RA_W-1:0]   s_addr,
    input  logic [RA_W-1:0]   w_addr,
    input  logic              set_flags,
    input  logic              ld_en,
    input  logic [RA_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_TST = 3'b111;

    typedef struct packed {
        logic [2:0]        alu_op;
        logic [1:0]        shift_op;
        logic              sel_shift;
        logic [7:0]        shift_imm;
        logic              sel_a;
        logic              sel_b;
        logic [DATA_W-1:0] imm;
        logic [RA_W-1:0]   a_addr;
        logic [RA_W-1:0]   b_addr;
        logic [RA_W-1:0]   s_addr;
        logic [RA_W-1:0]   w_addr;
        logic              set_flags;
    } op_t;

    logic [1:0]        state_reg, state_next;
    op_t               op_reg;
    logic [DATA_W-1:0] rf [NREGS];
    logic [DATA_W-1:0] a_reg, b_reg, c_reg;
    logic [7:0]        s_reg;
    logic [3:0]        flags_reg;

    logic              accept;
    logic              no_dest;
    logic              wb_we;

    assign in_ready = (state_reg == S_IDLE) | (state_reg == S_WB);
    assign accept   = in_valid & in_ready;
    assign no_dest  = (op_reg.alu_op == OP_CMP) | (op_reg.alu_op == OP_TST);
    assign wb_we    = (state_reg == S_WB) & ~no_dest;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = accept ? S_READ : S_IDLE;
            S_READ:  state_next = S_EXEC;
            S_EXEC:  state_next = S_WB;
            default: state_next = accept ? S_READ : S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg <= '{alu_op: alu_op, shift_op: shift_op, sel_shift: sel_shift,
                            shift_imm: shift_imm, sel_a: sel_A, sel_b: sel_B, imm: imm,
                            a_addr: a_addr, b_addr: b_addr, s_addr: s_addr,
                            w_addr: w_addr, set_flags: set_flags};
            end
        end
    end

    // Writeback has priority over a load to the same register on the same edge.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
        logic [DATA_W-1:0] q_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_reg <= '0;
            end else if (wb_we && op_reg.w_addr == RA_W'(gi)) begin
                q_reg <= c_reg;
            end else if (ld_en && ld_addr == RA_W'(gi)) begin
                q_reg <= ld_data;
            end
        end
        assign rf[gi] = q_reg;
    end

    // Only the low byte of the shift-amount register is ever used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
        end else if (state_reg == S_READ) begin
            a_reg <= rf[op_reg.a_addr];
            b_reg <= rf[op_reg.b_addr];
            s_reg <= rf[op_reg.s_addr][7:0];
        end
    end

    logic [7:0]        sh_amt;
    logic              sh_big;
    logic [SH_W-1:0]   ror_amt;
    logic [DATA_W-1:0] shift_out;

    always_comb begin
        sh_amt  = op_reg.sel_shift ? s_reg : op_reg.shift_imm;
        sh_big  = (32'(sh_amt) >= 32'(DATA_W));
        ror_amt = SH_W'(32'(sh_amt) % 32'(DATA_W));
        shift_out = b_reg;
        case (op_reg.shift_op)
            2'b00:   shift_out = sh_big ? '0 : (b_reg << sh_amt);
            2'b01:   shift_out = sh_big ? '0 : (b_reg >> sh_amt);
            2'b10:   shift_out = sh_big ? {DATA_W{b_reg[DATA_W-1]}}
                                        : DATA_W'($signed(b_reg) >>> sh_amt);
            default: shift_out = (b_reg >> ror_amt) | (b_reg << (32'(DATA_W) - 32'(ror_amt)));
        endcase
    end

    logic [DATA_W-1:0] op_a, op_b, alu_res;
    logic [DATA_W:0]   sum, diff;
    logic              alu_c, alu_v, flag_upd;

    always_comb begin
        op_a    = op_reg.sel_a ? '0 : a_reg;
        op_b    = op_reg.sel_b ? op_reg.imm : shift_out;
        sum     = {1'b0, op_a} + {1'b0, op_b};
        diff    = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = op_b;
        alu_c   = flags_reg[1];
        alu_v   = flags_reg[0];
        case (op_reg.alu_op)
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) & (sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];
                alu_v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) & (diff[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND, OP_TST: alu_res = op_a & op_b;
            OP_ORR:         alu_res = op_a | op_b;
            OP_EOR:         alu_res = op_a ^ op_b;
            OP_MOV:         alu_res = op_b;
            default:        alu_res = op_b;
        endcase
        flag_upd = op_reg.set_flags | no_dest;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_reg     <= '0;
            flags_reg <= 4'b0000;
        end else if (state_reg == S_EXEC) begin
            c_reg <= alu_res;
            if (flag_upd) begin
                flags_reg <= {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
            end
        end
    end

    assign out_valid = (state_reg == S_WB);
    assign result    = c_reg;
    assign flags     = flags_reg;

endmodule
